reg_bank_arbiter: RTL and testbench

Owns the five 8-bit configuration registers (output enables, PWM-mode enables, PWM duty cycle) and arbitrates write access between two requesters: the SPI frame decoder (port A) and an on-chip sequencer (port B). Writes are serialised through a small FSM with round-robin fairness. Duty-cycle updates are optionally double-buffered so they take effect only at a PWM period boundary. It sits between the SPI front end/sequencer and the PWM/output-enable logic.

---
 rtl/reg_bank_pkg.sv | 20 ++
 rtl/rr_arbiter_2.sv | 45 ++++
 rtl/reg_bank_arbiter.sv | 164 ++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - register map, FSM state and requester-id types for reg_bank_arbiter
package reg_bank_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-input round-robin grant with last_grant register
module rr_arbiter_2
  import reg_bank_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic update_en,
  output logic grant_valid,
  output logic grant_id
);

  req_e last_grant_q, last_grant_d;
  req_e winner;

  always_comb begin
    winner = REQ_A;
    if (req_a && req_b) begin
      // On a tie the side that did not win last time goes first.
      winner = (last_grant_q == REQ_B) ? REQ_A : REQ_B;
    end else if (req_b) begin
      winner = REQ_B;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update_en && grant_valid) begin
      last_grant_d = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign grant_valid = req_a | req_b;
  assign grant_id    = winner;

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - five config registers with two-port round-robin write arbitration
// REG_ARB_DUTY_SYNC_EN: double-buffer the duty cycle and apply it on pwm_sync.
module reg_bank_arbiter
  import reg_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       pwm_sync,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       duty_pending,
  output logic       err_addr
);

  state_e     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       a_ready_q, a_ready_d;
  logic       b_ready_q, b_ready_d;
  logic [7:0] en_out_lo_q, en_out_lo_d;
  logic [7:0] en_out_hi_q, en_out_hi_d;
  logic [7:0] en_pwm_lo_q, en_pwm_lo_d;
  logic [7:0] en_pwm_hi_q, en_pwm_hi_d;
  logic [7:0] duty_q, duty_d;
  logic       err_q, err_d;
`ifdef REG_ARB_DUTY_SYNC_EN
  logic [7:0] shadow_q, shadow_d;
  logic       pending_q, pending_d;
`else
  logic       sync_unused;
  assign sync_unused = pwm_sync;
`endif

  logic grant_valid;
  logic grant_id;
  logic grant_en;

  assign grant_en = (state_q == IDLE) && grant_valid;

  rr_arbiter_2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_a       (a_valid),
    .req_b       (b_valid),
    .update_en   (grant_en),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    a_ready_d   = 1'b0;
    b_ready_d   = 1'b0;
    en_out_lo_d = en_out_lo_q;
    en_out_hi_d = en_out_hi_q;
    en_pwm_lo_d = en_pwm_lo_q;
    en_pwm_hi_d = en_pwm_hi_q;
    duty_d      = duty_q;
    err_d       = err_q;
`ifdef REG_ARB_DUTY_SYNC_EN
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    // Sync is evaluated before the commit so a same-cycle commit stays pending.
    if (pwm_sync && pending_q) begin
      duty_d    = shadow_q;
      pending_d = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d   = WRITE;
          addr_d    = (grant_id == REQ_B) ? b_addr : a_addr;
          data_d    = (grant_id == REQ_B) ? b_data : a_data;
          a_ready_d = (grant_id == REQ_A);
          b_ready_d = (grant_id == REQ_B);
        end
      end
      WRITE: begin
        state_d = IDLE;
        case (addr_q)
          ADDR_EN_OUT_LO: en_out_lo_d = data_q;
          ADDR_EN_OUT_HI: en_out_hi_d = data_q;
          ADDR_EN_PWM_LO: en_pwm_lo_d = data_q;
          ADDR_EN_PWM_HI: en_pwm_hi_d = data_q;
          ADDR_DUTY: begin
`ifdef REG_ARB_DUTY_SYNC_EN
            shadow_d  = data_q;
            pending_d = 1'b1;
`else
            duty_d    = data_q;
`endif
          end
          default: err_d = 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      en_out_lo_q <= '0;
      en_out_hi_q <= '0;
      en_pwm_lo_q <= '0;
      en_pwm_hi_q <= '0;
      duty_q      <= '0;
      err_q       <= 1'b0;
`ifdef REG_ARB_DUTY_SYNC_EN
      shadow_q    <= '0;
      pending_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      a_ready_q   <= a_ready_d;
      b_ready_q   <= b_ready_d;
      en_out_lo_q <= en_out_lo_d;
      en_out_hi_q <= en_out_hi_d;
      en_pwm_lo_q <= en_pwm_lo_d;
      en_pwm_hi_q <= en_pwm_hi_d;
      duty_q      <= duty_d;
      err_q       <= err_d;
`ifdef REG_ARB_DUTY_SYNC_EN
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
`endif
    end
  end

  assign a_ready         = a_ready_q;
  assign b_ready         = b_ready_q;
  assign en_reg_out_7_0  = en_out_lo_q;
  assign en_reg_out_15_8 = en_out_hi_q;
  assign en_reg_pwm_7_0  = en_pwm_lo_q;
  assign en_reg_pwm_15_8 = en_pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign err_addr        = err_q;
`ifdef REG_ARB_DUTY_SYNC_EN
  assign duty_pending    = pending_q;
`else
  assign duty_pending    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       pwm_sync = 1'b0;
  logic       a_ready, b_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       duty_pending, err_addr;

  always #5 clk = ~clk;

  reg_bank_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .a_valid         (a_valid),
    .a_addr          (a_addr),
    .a_data          (a_data),
    .a_ready         (a_ready),
    .b_valid         (b_valid),
    .b_addr          (b_addr),
    .b_data          (b_data),
    .b_ready         (b_ready),
    .pwm_sync        (pwm_sync),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .duty_pending    (duty_pending),
    .err_addr        (err_addr)
  );

  typedef struct {
    logic       port;
    logic [6:0] addr;
    logic [7:0] data;
  } req_t;

  typedef struct {
    logic       port;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  req_t exp_q[$];
  logic [7:0] m_reg [5];
  logic m_err;
  logic commit_due;
  req_t commit_req;
`ifdef REG_ARB_DUTY_SYNC_EN
  logic [7:0] m_shadow;
  logic m_pending;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    m_err      = 1'b0;
    commit_due = 1'b0;
    exp_q.delete();
`ifdef REG_ARB_DUTY_SYNC_EN
    m_shadow  = 8'h00;
    m_pending = 1'b0;
`endif
  endtask

  task automatic check_outputs();
    chk("en_out_lo", en_reg_out_7_0, m_reg[0]);
    chk("en_out_hi", en_reg_out_15_8, m_reg[1]);
    chk("en_pwm_lo", en_reg_pwm_7_0, m_reg[2]);
    chk("en_pwm_hi", en_reg_pwm_15_8, m_reg[3]);
    chk("duty", pwm_duty_cycle, m_reg[4]);
    chk("err_addr", err_addr, m_err);
`ifdef REG_ARB_DUTY_SYNC_EN
    chk("duty_pending", duty_pending, m_pending);
`else
    chk("duty_pending", duty_pending, 0);
`endif
  endtask

  // Advance one clock, update the reference model for this edge, then score ready and outputs.
  task automatic tick();
    logic sync_now;
    logic do_commit;
    req_t r;
    sync_now   = pwm_sync;
    do_commit  = commit_due;
    r          = commit_req;
    commit_due = 1'b0;
    @(posedge clk);
    #1;
`ifdef REG_ARB_DUTY_SYNC_EN
    if (sync_now && m_pending) begin
      m_reg[4]  = m_shadow;
      m_pending = 1'b0;
    end
`endif
    if (do_commit) begin
      if (r.addr <= 7'h04) begin
`ifdef REG_ARB_DUTY_SYNC_EN
        if (r.addr == 7'h04) begin
          m_shadow  = r.data;
          m_pending = 1'b1;
        end else begin
          m_reg[r.addr[2:0]] = r.data;
        end
`else
        m_reg[r.addr[2:0]] = r.data;
`endif
      end else begin
        m_err = 1'b1;
      end
    end
    if (a_ready || b_ready) begin
      tests++;
      if (a_ready && b_ready) begin
        fails++;
        $display("FAIL both_ready: got a=1 b=1 expected one-hot");
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: got a=%0d b=%0d expected none", a_ready, b_ready);
      end else begin
        r = exp_q.pop_front();
        if (r.port != b_ready) begin
          fails++;
          $display("FAIL grant_order: got port %0d expected port %0d", b_ready, r.port);
        end
        commit_due = 1'b1;
        commit_req = r;
      end
    end
    check_outputs();
  endtask

  task automatic wait_ready(input logic port, input int max, output int n);
    n = 0;
    tick();
    n++;
    while (!(port ? b_ready : a_ready) && n < max) begin
      tick();
      n++;
    end
    tests++;
    if (!(port ? b_ready : a_ready)) begin
      fails++;
      $display("FAIL ready_timeout: got no ready on port %0d after %0d cycles expected ready", port, n);
    end
  endtask

  task automatic drive(input logic port, input logic v, input logic [6:0] addr, input logic [7:0] data);
    if (port) begin
      b_valid = v; b_addr = addr; b_data = data;
    end else begin
      a_valid = v; a_addr = addr; a_data = data;
    end
  endtask

  task automatic do_write(input logic port, input logic [6:0] addr, input logic [7:0] data,
                          input logic sync_at_commit);
    req_t r;
    int   n;
    r.port = port; r.addr = addr; r.data = data;
    exp_q.push_back(r);
    drive(port, 1'b1, addr, data);
    wait_ready(port, 10, n);
    chk("req_latency", n, 1);
    if (sync_at_commit) pwm_sync = 1'b1;
    tick();
    pwm_sync = 1'b0;
    drive(port, 1'b0, addr, data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; pwm_sync = 1'b0;
    #1;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_pair(input logic first);
    req_t r0, r1;
    int   n;
    r0.port = first;  r0.addr = first ? 7'h01 : 7'h02; r0.data = first ? 8'h44 : 8'h11;
    r1.port = !first; r1.addr = first ? 7'h00 : 7'h03; r1.data = first ? 8'h33 : 8'h22;
    exp_q.push_back(r0);
    exp_q.push_back(r1);
    drive(r0.port, 1'b1, r0.addr, r0.data);
    drive(r1.port, 1'b1, r1.addr, r1.data);
    wait_ready(r0.port, 10, n);
    chk("pair_first_latency", n, 1);
    chk("pair_loser_not_ready", r1.port ? b_ready : a_ready, 0);
    tick();
    drive(r0.port, 1'b0, r0.addr, r0.data);
    wait_ready(r1.port, 10, n);
    chk("pair_second_latency", n, 1);
    tick();
    drive(r1.port, 1'b0, r1.addr, r1.data);
  endtask

  function automatic logic [7:0] reg_by_addr(input logic [6:0] a);
    case (a)
      7'h00:   return en_reg_out_7_0;
      7'h01:   return en_reg_out_15_8;
      7'h02:   return en_reg_pwm_7_0;
      7'h03:   return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 7'h01, 8'h3C, 8'h3C};
    vecs[1] = '{1'b1, 7'h00, 8'hC3, 8'hC3};
    vecs[2] = '{1'b0, 7'h02, 8'hFF, 8'hFF};
    vecs[3] = '{1'b1, 7'h03, 8'h5A, 8'h5A};
    vecs[4] = '{1'b1, 7'h01, 8'h7E, 8'h7E};
    vecs[5] = '{1'b0, 7'h03, 8'h81, 8'h81};

    model_reset();
    do_reset();
    chk("reset_a_ready", a_ready, 0);
    chk("reset_b_ready", b_ready, 0);

    do_write(1'b0, 7'h00, 8'hA5, 1'b0);
    chk("first_write", en_reg_out_7_0, 8'hA5);

    do_reset();
    do_pair(1'b0);
    chk("pair_a_reg", en_reg_pwm_7_0, 8'h11);
    chk("pair_b_reg", en_reg_pwm_15_8, 8'h22);
    do_write(1'b0, 7'h02, 8'h12, 1'b0);
    do_pair(1'b1);
    chk("pair2_b_reg", en_reg_out_15_8, 8'h44);
    chk("pair2_a_reg", en_reg_out_7_0, 8'h33);

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].port, vecs[i].addr, vecs[i].data, 1'b0);
      chk("table_reg", reg_by_addr(vecs[i].addr), vecs[i].exp);
    end

`ifdef REG_ARB_DUTY_SYNC_EN
    do_write(1'b1, 7'h04, 8'h80, 1'b0);
    chk("sync_held_duty", pwm_duty_cycle, 8'h00);
    chk("sync_held_pending", duty_pending, 1);
    pwm_sync = 1'b1;
    tick();
    pwm_sync = 1'b0;
    chk("sync_applied_duty", pwm_duty_cycle, 8'h80);
    chk("sync_applied_pending", duty_pending, 0);
    do_write(1'b1, 7'h04, 8'h55, 1'b0);
    do_write(1'b0, 7'h04, 8'h33, 1'b1);
    chk("same_cycle_duty", pwm_duty_cycle, 8'h55);
    chk("same_cycle_pending", duty_pending, 1);
    tick();
    pwm_sync = 1'b1;
    tick();
    pwm_sync = 1'b0;
    chk("next_sync_duty", pwm_duty_cycle, 8'h33);
`else
    do_write(1'b1, 7'h04, 8'h40, 1'b0);
    chk("direct_duty", pwm_duty_cycle, 8'h40);
    for (int i = 0; i < 4; i++) begin
      pwm_sync = ~pwm_sync;
      tick();
    end
    pwm_sync = 1'b0;
    chk("sync_ignored_duty", pwm_duty_cycle, 8'h40);
    chk("sync_ignored_pending", duty_pending, 0);
`endif

    do_write(1'b0, 7'h7F, 8'hFF, 1'b0);
    chk("err_set", err_addr, 1);
    do_write(1'b0, 7'h05, 8'h01, 1'b0);
    do_write(1'b1, 7'h00, 8'h0F, 1'b0);
    chk("err_sticky", err_addr, 1);

    begin
      req_t r;
      int   n;
      r.port = 1'b0; r.addr = 7'h01; r.data = 8'h5A;
      exp_q.push_back(r);
      drive(1'b0, 1'b1, 7'h01, 8'h5A);
      wait_ready(1'b0, 10, n);
      rst_n = 1'b0;
      #1;
      chk("async_reset_ready", a_ready, 0);
      model_reset();
      check_outputs();
      a_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("reset_write_lost", en_reg_out_15_8, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
